// File: rtl/lb_dispatch_pkg.sv
// lb_dispatch_pkg: shared types and the circular lane search used by rr_dispatcher.
// Revision: 1.0
`default_nettype none

package lb_dispatch_pkg;

  localparam int MAX_LANES = 16;
  localparam int STAT_W    = 32;

  typedef logic [$clog2(MAX_LANES)-1:0] lane_idx_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_OFFER = 1'b1
  } buf_state_t;

  // First enabled lane after cur (wrapping over n lanes); cur itself when none other is enabled.
  function automatic lane_idx_t next_lane(input lane_idx_t              cur,
                                          input logic [MAX_LANES-1:0] mask,
                                          input int                   n);
    lane_idx_t sel;
    lane_idx_t idx;
    logic      found;
    sel   = cur;
    found = 1'b0;
    for (int k = 1; k < MAX_LANES; k++) begin
      idx = lane_idx_t'((int'(cur) + k) % n);
      if (k < n && !found && mask[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_dispatcher_upcounter.sv
// rr_dispatcher_upcounter: saturating up-counter, cleared whenever en_i is low; max_tick_o at all-ones.
// Revision: 1.0
`default_nettype none

module rr_dispatcher_upcounter #(
  parameter int COUNT_BITS = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic en_i,
  output logic max_tick_o
);

  logic [COUNT_BITS-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (!en_i) begin
      count_q <= '0;
    end else if (count_q != '1) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign max_tick_o = (count_q == '1);

endmodule

`default_nettype wire

// File: rtl/rr_dispatcher.sv
// rr_dispatcher: round-robin valid/ready dispatcher with lane masking and stall-timeout failover.
// Optional statistics outputs under macro DISPATCH_STATS_EN.  Revision: 1.0
`default_nettype none

module rr_dispatcher
  import lb_dispatch_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int DATA_W       = 64,
  parameter int TIMEOUT_BITS = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_W-1:0]            s_data,
  input  logic [NUM_LANES-1:0]         lane_mask,
  output logic [NUM_LANES-1:0]         m_valid,
  input  logic [NUM_LANES-1:0]         m_ready,
  output logic [DATA_W-1:0]            m_data,
  output logic [$clog2(NUM_LANES)-1:0] cur_lane,
  output logic                         timeout_pulse
`ifdef DISPATCH_STATS_EN
  ,
  output logic [STAT_W-1:0]            stat_beats,
  output logic [STAT_W-1:0]            stat_timeouts
`endif
);

  localparam int LW = $clog2(NUM_LANES);

  buf_state_t       state_q;
  logic [DATA_W-1:0] data_q;
  logic [LW-1:0]    cur_lane_q;
  logic [LW-1:0]    cur_lane_d;
  logic             pulse_q;

  logic                 w_full;
  logic                 w_cur_en;
  logic [NUM_LANES-1:0] w_m_valid;
  logic                 w_xfer;
  logic                 w_s_ready;
  logic                 w_accept;
  logic                 w_timer_en;
  logic                 w_max_tick;
  logic                 w_failover;
  logic                 w_advance;

  assign w_full     = (state_q == BUF_OFFER);
  assign w_cur_en   = lane_mask[cur_lane_q];
  assign w_m_valid  = (w_full && w_cur_en) ? (NUM_LANES'(1) << cur_lane_q) : '0;
  assign w_xfer     = |(w_m_valid & m_ready);
  assign w_s_ready  = !w_full || w_xfer;
  assign w_accept   = s_valid && w_s_ready;

  // The enable drops on max_tick so the timer restarts from zero after every failover.
  assign w_timer_en = w_full && !m_ready[cur_lane_q] && w_cur_en && !w_max_tick;
  assign w_failover = w_max_tick && w_full && !w_xfer;
  assign w_advance  = w_xfer || w_failover || (w_full && !w_cur_en);

  rr_dispatcher_upcounter #(
    .COUNT_BITS (TIMEOUT_BITS)
  ) u_stall_timer (
    .clk        (clk),
    .resetn     (resetn),
    .en_i       (w_timer_en),
    .max_tick_o (w_max_tick)
  );

  always_comb begin
    cur_lane_d = cur_lane_q;
    if (w_advance) begin
      cur_lane_d = LW'(next_lane(lane_idx_t'(cur_lane_q), MAX_LANES'(lane_mask), NUM_LANES));
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= BUF_EMPTY;
      data_q     <= '0;
      cur_lane_q <= '0;
      pulse_q    <= 1'b0;
    end else begin
      case (state_q)
        BUF_EMPTY: if (w_accept) state_q <= BUF_OFFER;
        BUF_OFFER: if (w_xfer && !w_accept) state_q <= BUF_EMPTY;
        default:   state_q <= BUF_EMPTY;
      endcase
      if (w_accept) data_q <= s_data;
      cur_lane_q <= cur_lane_d;
      pulse_q    <= w_failover;
    end
  end

  assign s_ready       = w_s_ready;
  assign m_valid       = w_m_valid;
  assign m_data        = data_q;
  assign cur_lane      = cur_lane_q;
  assign timeout_pulse = pulse_q;

`ifdef DISPATCH_STATS_EN
  logic [STAT_W-1:0] beats_q;
  logic [STAT_W-1:0] timeouts_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      beats_q    <= '0;
      timeouts_q <= '0;
    end else begin
      if (w_xfer && beats_q != '1)        beats_q    <= beats_q + 1'b1;
      if (w_failover && timeouts_q != '1) timeouts_q <= timeouts_q + 1'b1;
    end
  end

  assign stat_beats    = beats_q;
  assign stat_timeouts = timeouts_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_dispatcher.sv
// tb_rr_dispatcher: vector table, directed corner sequences and randomized traffic vs. a behavioural model.
`default_nettype none

module tb_rr_dispatcher;

  localparam int N    = 4;
  localparam int DW   = 64;
  localparam int TB   = 3;
  localparam int MAXV = (1 << TB) - 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic [N-1:0]  lane_mask;
  logic [N-1:0]  m_valid;
  logic [N-1:0]  m_ready;
  logic [DW-1:0] m_data;
  logic [1:0]    cur_lane;
  logic          timeout_pulse;
`ifdef DISPATCH_STATS_EN
  logic [31:0]   stat_beats;
  logic [31:0]   stat_timeouts;
`endif

  rr_dispatcher #(.NUM_LANES(N), .DATA_W(DW), .TIMEOUT_BITS(TB)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .lane_mask     (lane_mask),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .cur_lane      (cur_lane),
    .timeout_pulse (timeout_pulse)
`ifdef DISPATCH_STATS_EN
    ,
    .stat_beats    (stat_beats),
    .stat_timeouts (stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: buffer occupancy, lane pointer and a count of consecutive refused offers.
  bit          mdl_ok = 0;
  bit          mh;
  logic [63:0] mbeat;
  int          mptr;
  int          mrun;
  bit          mpulse;
  int unsigned mbeats;
  int unsigned mtouts;

  function automatic int nxt(input int p, input logic [N-1:0] mask);
    for (int k = 1; k < N; k++) begin
      if (mask[(p + k) % N]) return (p + k) % N;
    end
    return p;
  endfunction

  task automatic model_step();
    bit offered, acc, fail, sr, refused;
    logic [N-1:0] emv;
    offered = mh && lane_mask[mptr];
    emv     = offered ? N'(1 << mptr) : '0;
    acc     = offered && m_ready[mptr];
    refused = offered && !m_ready[mptr];
    sr      = !mh || acc;
    fail    = mh && !acc && (mrun == MAXV);
    if (mdl_ok) begin
      chk("mdl_m_valid", 64'(m_valid), 64'(emv));
      chk("mdl_s_ready", 64'(s_ready), 64'(sr));
      chk("mdl_m_data", m_data, mbeat);
      chk("mdl_cur_lane", 64'(cur_lane), 64'(mptr));
      chk("mdl_timeout_pulse", 64'(timeout_pulse), 64'(mpulse));
`ifdef DISPATCH_STATS_EN
      chk("mdl_stat_beats", 64'(stat_beats), 64'(mbeats));
      chk("mdl_stat_timeouts", 64'(stat_timeouts), 64'(mtouts));
`endif
    end
    if (!resetn) begin
      mh = 0; mbeat = '0; mptr = 0; mrun = 0; mpulse = 0; mbeats = 0; mtouts = 0;
      mdl_ok = 1;
    end else begin
      if (acc || fail || (mh && !lane_mask[mptr])) mptr = nxt(mptr, lane_mask);
      mrun   = fail ? 0 : (refused ? mrun + 1 : 0);
      mpulse = fail;
      mbeats = mbeats + (acc ? 1 : 0);
      mtouts = mtouts + (fail ? 1 : 0);
      if (s_valid && sr) begin
        mh = 1; mbeat = s_data;
      end else if (acc) begin
        mh = 0;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_step();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    settle();
    adv();
    resetn = 1'b1;
  endtask

  task automatic send_beat(input logic [63:0] d);
    bit done;
    done    = 0;
    s_valid = 1'b1;
    s_data  = d;
    for (int k = 0; k < 20 && !done; k++) begin
      settle();
      done = s_ready;
      adv();
    end
    s_valid = 1'b0;
    chk("send_accept", 64'(done), 64'd1);
  endtask

  typedef struct {
    logic         sv;
    logic [63:0]  sd;
    logic [N-1:0] mask;
    logic [N-1:0] rdy;
    logic [N-1:0] e_mv;
    logic         e_sr;
    logic [1:0]   e_cur;
    logic [63:0]  e_md;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic [63:0] sd, input logic [N-1:0] mask,
                              input logic [N-1:0] rdy, input logic [N-1:0] e_mv, input logic e_sr,
                              input logic [1:0] e_cur, input logic [63:0] e_md);
    vec_t v;
    v.sv = sv; v.sd = sd; v.mask = mask; v.rdy = rdy;
    v.e_mv = e_mv; v.e_sr = e_sr; v.e_cur = e_cur; v.e_md = e_md;
    return v;
  endfunction

  function automatic logic [63:0] dk(input int k);
    return 64'h1111_0000_0000_0000 | 64'(k);
  endfunction

  vec_t tbl[16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cnt, pc, off;
    bit          found, f_cur, f_sr, f_mv, f_md;
    logic [19:0] pmask;
    int          busy_pct;

    // Round-robin over all lanes, then alternating lanes 1/3 with lane 0 masked.
    tbl[0]  = mk(1, dk(0),  4'hf, 4'hf, 4'b0000, 1, 0, 64'h0);
    tbl[1]  = mk(1, dk(1),  4'hf, 4'hf, 4'b0001, 1, 0, dk(0));
    tbl[2]  = mk(1, dk(2),  4'hf, 4'hf, 4'b0010, 1, 1, dk(1));
    tbl[3]  = mk(1, dk(3),  4'hf, 4'hf, 4'b0100, 1, 2, dk(2));
    tbl[4]  = mk(1, dk(4),  4'hf, 4'hf, 4'b1000, 1, 3, dk(3));
    tbl[5]  = mk(1, dk(5),  4'hf, 4'hf, 4'b0001, 1, 0, dk(4));
    tbl[6]  = mk(1, dk(6),  4'hf, 4'hf, 4'b0010, 1, 1, dk(5));
    tbl[7]  = mk(1, dk(7),  4'hf, 4'hf, 4'b0100, 1, 2, dk(6));
    tbl[8]  = mk(0, 64'h0,  4'hf, 4'hf, 4'b1000, 1, 3, dk(7));
    tbl[9]  = mk(0, 64'h0,  4'hf, 4'hf, 4'b0000, 1, 0, dk(7));
    tbl[10] = mk(1, dk(8),  4'ha, 4'hf, 4'b0000, 1, 0, dk(7));
    tbl[11] = mk(1, dk(9),  4'ha, 4'hf, 4'b0000, 0, 0, dk(8));
    tbl[12] = mk(1, dk(9),  4'ha, 4'hf, 4'b0010, 1, 1, dk(8));
    tbl[13] = mk(1, dk(10), 4'ha, 4'hf, 4'b1000, 1, 3, dk(9));
    tbl[14] = mk(0, 64'h0,  4'ha, 4'hf, 4'b0010, 1, 1, dk(10));
    tbl[15] = mk(0, 64'h0,  4'ha, 4'hf, 4'b0000, 1, 3, dk(10));

    resetn = 1'b0; s_valid = 1'b0; s_data = '0; lane_mask = 4'hf; m_ready = 4'hf;
    repeat (2) begin settle(); adv(); end
    resetn = 1'b1;

    settle();
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd1);
    chk("rst_cur_lane", 64'(cur_lane), 64'd0);
    chk("rst_timeout_pulse", 64'(timeout_pulse), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    adv();

    for (int i = 0; i < 16; i++) begin
      s_valid = tbl[i].sv; s_data = tbl[i].sd; lane_mask = tbl[i].mask; m_ready = tbl[i].rdy;
      settle();
      chk($sformatf("vec%0d_m_valid", i), 64'(m_valid), 64'(tbl[i].e_mv));
      chk($sformatf("vec%0d_s_ready", i), 64'(s_ready), 64'(tbl[i].e_sr));
      chk($sformatf("vec%0d_cur_lane", i), 64'(cur_lane), 64'(tbl[i].e_cur));
      chk($sformatf("vec%0d_m_data", i), m_data, tbl[i].e_md);
      adv();
    end
    s_valid = 1'b0;

    // Lane 0 never ready: offered MAX+1 cycles, one failover, then lane 1 takes the beat.
    do_reset();
    lane_mask = 4'hf; m_ready = 4'b1110;
    send_beat(64'hA5A5_0000_0000_000A);
    cnt = 0; pc = 0; off = -1;
    for (int k = 0; k < 12; k++) begin
      settle();
      if (m_valid == 4'b0001) cnt++;
      if (timeout_pulse) pc++;
      if (m_valid == 4'b0010 && off < 0) begin
        off = k;
        chk("to_lane1_data", m_data, 64'hA5A5_0000_0000_000A);
      end
      adv();
    end
    chk("to_lane0_offer_cycles", 64'(cnt), 64'd8);
    chk("to_pulse_count", 64'(pc), 64'd1);
    chk("to_lane1_offset", 64'(off), 64'd8);

    // Only lane 0 enabled and stalled: repeated failovers onto itself.
    do_reset();
    lane_mask = 4'b0001; m_ready = 4'b0000;
    send_beat(64'hBBBB_0000_0000_000B);
    pmask = '0; f_cur = 1; f_sr = 1; f_mv = 1; f_md = 1;
    for (int k = 0; k < 20; k++) begin
      settle();
      if (timeout_pulse) pmask[k] = 1'b1;
      if (cur_lane != 2'd0) f_cur = 0;
      if (s_ready) f_sr = 0;
      if (m_valid != 4'b0001) f_mv = 0;
      if (m_data != 64'hBBBB_0000_0000_000B) f_md = 0;
      adv();
    end
    chk("sl_pulse_offsets", 64'(pmask), 64'h10100);
    chk("sl_cur_constant", 64'(f_cur), 64'd1);
    chk("sl_s_ready_low", 64'(f_sr), 64'd1);
    chk("sl_m_valid_held", 64'(f_mv), 64'd1);
    chk("sl_beat_kept", 64'(f_md), 64'd1);
    m_ready = 4'b0001;
    settle();
    chk("sl_release_m_valid", 64'(m_valid), 64'b0001);
    adv();
    settle();
    chk("sl_after_release_empty", 64'(m_valid), 64'd0);
    adv();

    // Ready arrives exactly on the max_tick cycle: delivery wins over failover.
    do_reset();
    lane_mask = 4'hf; m_ready = 4'b0000;
    send_beat(64'hCCCC_0000_0000_000C);
    pc = 0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) m_ready = 4'b0001;
      settle();
      if (timeout_pulse) pc++;
      if (k == 7) chk("xm_m_valid", 64'(m_valid), 64'b0001);
      adv();
    end
    for (int k = 0; k < 3; k++) begin
      settle();
      if (timeout_pulse) pc++;
      if (k == 0) begin
        chk("xm_cur_lane", 64'(cur_lane), 64'd1);
        chk("xm_empty", 64'(m_valid), 64'd0);
      end
      adv();
    end
    chk("xm_no_pulse", 64'(pc), 64'd0);

    // Mask the current lane mid-offer: offer drops at once, beat redirected to lane 1.
    do_reset();
    lane_mask = 4'b1010; m_ready = 4'b0111;
    send_beat(64'hDDDD_0000_0000_000D);
    send_beat(64'hEEEE_0000_0000_000E);
    found = 0;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (m_valid == 4'b1000) begin
        found = 1;
        break;
      end
      adv();
    end
    chk("mm_offer_lane3", 64'(found), 64'd1);
    adv();
    lane_mask = 4'b0010;
    settle();
    chk("mm_drop_m_valid", 64'(m_valid), 64'd0);
    chk("mm_cur_hold", 64'(cur_lane), 64'd3);
    adv();
    settle();
    chk("mm_redirect_m_valid", 64'(m_valid), 64'b0010);
    chk("mm_redirect_data", m_data, 64'hEEEE_0000_0000_000E);
    chk("mm_redirect_cur", 64'(cur_lane), 64'd1);
    adv();
    settle();
    chk("mm_delivered", 64'(m_valid), 64'd0);
    chk("mm_no_pulse", 64'(timeout_pulse), 64'd0);
    adv();

    // Reset mid-offer, then hold a beat with every lane masked, then restore the mask.
    do_reset();
    lane_mask = 4'hf; m_ready = 4'b0000;
    send_beat(64'hF0F0_0000_0000_00F0);
    settle(); adv();
    settle(); adv();
    resetn = 1'b0;
    settle(); adv();
    resetn = 1'b1;
    settle();
    chk("rm_m_valid", 64'(m_valid), 64'd0);
    chk("rm_m_data", m_data, 64'd0);
    chk("rm_cur_lane", 64'(cur_lane), 64'd0);
    chk("rm_s_ready", 64'(s_ready), 64'd1);
    chk("rm_pulse", 64'(timeout_pulse), 64'd0);
`ifdef DISPATCH_STATS_EN
    chk("rm_stat_beats", 64'(stat_beats), 64'd0);
    chk("rm_stat_timeouts", 64'(stat_timeouts), 64'd0);
`endif
    adv();
    lane_mask = 4'b0000;
    send_beat(64'h0E0E_0000_0000_0E0E);
    f_mv = 1; f_sr = 1; f_cur = 1; pc = 0;
    for (int k = 0; k < 12; k++) begin
      settle();
      if (m_valid != 4'b0000) f_mv = 0;
      if (s_ready) f_sr = 0;
      if (cur_lane != 2'd0) f_cur = 0;
      if (timeout_pulse) pc++;
      adv();
    end
    chk("z_m_valid_zero", 64'(f_mv), 64'd1);
    chk("z_s_ready_low", 64'(f_sr), 64'd1);
    chk("z_cur_constant", 64'(f_cur), 64'd1);
    chk("z_no_pulse", 64'(pc), 64'd0);
    lane_mask = 4'hf;
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      settle();
      if (m_valid == 4'b0001) cnt++;
      adv();
    end
    chk("z_restored_offer_cycles", 64'(cnt), 64'd8);
    m_ready = 4'hf;
    settle(); adv();
    settle(); adv();

    // Randomized traffic; the model checks every cycle.
    busy_pct = 10;
    for (int c = 0; c < 1500; c++) begin
      if (c % 50 == 0) busy_pct = ($urandom_range(0, 2) == 0) ? 10 : (($urandom_range(0, 1) == 0) ? 50 : 95);
      if ($urandom_range(0, 99) < 4) lane_mask = 4'($urandom_range(0, 15));
      m_ready = ($urandom_range(0, 99) < busy_pct) ? 4'b0000 : 4'($urandom_range(0, 15));
      s_valid = ($urandom_range(0, 99) < 70);
      s_data  = {$urandom, $urandom};
      resetn  = !($urandom_range(0, 999) < 3);
      settle();
      adv();
    end
    resetn = 1'b1;
    s_valid = 1'b0;
    settle();
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
